ph_ac_mean_bank: RTL and testbench

//  Per-channel averager for the phase/amplitude results of the single-frequency DFT cascade.

---
 rtl/ph_ac_mean_bank.sv | 153 +++++++++++++++
 tb/tb_ph_ac_mean_bank.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ph_ac_mean_bank.sv
// Per-channel block averager for time-multiplexed phase/amplitude results.
// Averages 2^n samples per channel; phase is averaged relative to the block's first sample, so wrap is harmless.
module ph_ac_mean_bank #(
    parameter  int CHANELS        = 4,
    parameter  int MEAN_STEPS_MAX = 3,
    parameter  int PH_WIDTH       = 32,
    parameter  int AC_WIDTH       = 32,
    localparam int CW             = (CHANELS > 1) ? $clog2(CHANELS) : 1,
    localparam int NW             = $clog2(MEAN_STEPS_MAX + 1)
) (
    input  logic                       clk,
    input  logic                       rstn,
    input  logic                       i_vld,
    output logic                       i_rdy,
    input  logic [CW-1:0]              i_chan,
    input  logic signed [PH_WIDTH-1:0] i_ph,
    input  logic [AC_WIDTH-1:0]        i_ac,
    input  logic [NW-1:0]              i_mean_steps,
    input  logic                       i_clr,
    output logic                       o_vld,
    input  logic                       o_rdy,
    output logic [CW-1:0]              o_chan,
    output logic signed [PH_WIDTH-1:0] o_ph,
    output logic [AC_WIDTH-1:0]        o_ac,
    output logic                       o_err
);

    localparam int SW  = MEAN_STEPS_MAX;
    localparam int PAW = PH_WIDTH + MEAN_STEPS_MAX;
    localparam int AAW = AC_WIDTH + MEAN_STEPS_MAX;

    logic [SW-1:0]              cnt_q    [CHANELS];
    logic signed [PH_WIDTH-1:0] ref_q    [CHANELS];
    logic signed [PAW-1:0]      acc_ph_q [CHANELS];
    logic [AAW-1:0]             acc_ac_q [CHANELS];
    logic [NW-1:0]              n_q;

    function automatic logic [NW-1:0] sat_steps(input logic [NW-1:0] v);
        if (v > NW'(MEAN_STEPS_MAX))
            return NW'(MEAN_STEPS_MAX);
        return v;
    endfunction

    // Floor division of the signed offset sum, added back onto the reference modulo 2^PH_WIDTH.
    function automatic logic signed [PH_WIDTH-1:0] mean_ph(input logic signed [PH_WIDTH-1:0] base,
                                                           input logic signed [PAW-1:0]      sum,
                                                           input logic [NW-1:0]              n);
        logic signed [PAW-1:0] q;
        q = sum >>> n;
        return base + q[PH_WIDTH-1:0];
    endfunction

    function automatic logic [AC_WIDTH-1:0] mean_ac(input logic [AAW-1:0] sum,
                                                    input logic [NW-1:0]  n);
        logic [AAW-1:0] q;
        q = sum >> n;
        return q[AC_WIDTH-1:0];
    endfunction

    logic [NW-1:0]              n_sat;
    logic                       mode_chg;
    logic                       accept;
    logic                       chan_ok;
    logic [CW-1:0]              sel;
    logic [SW-1:0]              last_cnt;
    logic                       first;
    logic                       last;
    logic signed [PH_WIDTH-1:0] d;
    logic signed [PAW-1:0]      d_ext;
    logic signed [PH_WIDTH-1:0] base_ph;
    logic signed [PAW-1:0]      sum_ph;
    logic [AAW-1:0]             sum_ac;

    assign n_sat    = sat_steps(i_mean_steps);
    assign mode_chg = (n_sat != n_q);
    assign i_rdy    = (!o_vld || o_rdy) && !i_clr && !mode_chg;
    assign accept   = i_vld && i_rdy;
    assign chan_ok  = (32'(i_chan) < CHANELS);
    assign sel      = chan_ok ? i_chan : '0;
    assign last_cnt = ~({SW{1'b1}} << n_q);

    always_comb begin
        first   = (cnt_q[sel] == '0);
        last    = (cnt_q[sel] == last_cnt);
        d       = i_ph - ref_q[sel];
        d_ext   = {{MEAN_STEPS_MAX{d[PH_WIDTH-1]}}, d};
        base_ph = ref_q[sel];
        sum_ph  = acc_ph_q[sel] + d_ext;
        sum_ac  = acc_ac_q[sel] + AAW'(i_ac);
        // The first sample of a block becomes the reference, so its own offset is zero.
        if (first) begin
            base_ph = i_ph;
            sum_ph  = '0;
            sum_ac  = AAW'(i_ac);
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            n_q <= '0;
            for (int c = 0; c < CHANELS; c++) begin
                cnt_q[c]    <= '0;
                ref_q[c]    <= '0;
                acc_ph_q[c] <= '0;
                acc_ac_q[c] <= '0;
            end
        end else begin
            if (mode_chg)
                n_q <= n_sat;
            if (i_clr || mode_chg) begin
                for (int c = 0; c < CHANELS; c++) begin
                    cnt_q[c]    <= '0;
                    acc_ph_q[c] <= '0;
                    acc_ac_q[c] <= '0;
                end
            end else if (accept && chan_ok) begin
                if (last)
                    cnt_q[sel] <= '0;
                else
                    cnt_q[sel] <= cnt_q[sel] + 1'b1;
                if (first)
                    ref_q[sel] <= i_ph;
                acc_ph_q[sel] <= sum_ph;
                acc_ac_q[sel] <= sum_ac;
            end
        end
    end

    // Output register: a completion reloads it even on the edge that transfers the previous result.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            o_vld  <= 1'b0;
            o_chan <= '0;
            o_ph   <= '0;
            o_ac   <= '0;
        end else if (accept && chan_ok && last) begin
            o_vld  <= 1'b1;
            o_chan <= i_chan;
            o_ph   <= mean_ph(base_ph, sum_ph, n_q);
            o_ac   <= mean_ac(sum_ac, n_q);
        end else if (o_rdy) begin
            o_vld  <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn)
            o_err <= 1'b0;
        else if (accept && !chan_ok)
            o_err <= 1'b1;
    end

endmodule

// File: tb/tb_ph_ac_mean_bank.sv
// Randomised and directed bench for ph_ac_mean_bank against a block-averaging reference model.
module tb_ph_ac_mean_bank;

    localparam int CH  = 5;
    localparam int MSM = 4;

    logic        clk = 1'b0;
    logic        rstn;
    logic        i_vld;
    logic        i_rdy;
    logic [2:0]  i_chan;
    logic [31:0] i_ph;
    logic [31:0] i_ac;
    logic [2:0]  i_mean_steps;
    logic        i_clr;
    logic        o_vld;
    logic        o_rdy;
    logic [2:0]  o_chan;
    logic [31:0] o_ph;
    logic [31:0] o_ac;
    logic        o_err;

    ph_ac_mean_bank #(
        .CHANELS(CH), .MEAN_STEPS_MAX(MSM), .PH_WIDTH(32), .AC_WIDTH(32)
    ) dut (
        .clk(clk), .rstn(rstn), .i_vld(i_vld), .i_rdy(i_rdy), .i_chan(i_chan),
        .i_ph(i_ph), .i_ac(i_ac), .i_mean_steps(i_mean_steps), .i_clr(i_clr),
        .o_vld(o_vld), .o_rdy(o_rdy), .o_chan(o_chan), .o_ph(o_ph), .o_ac(o_ac),
        .o_err(o_err)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_bad = 0;

    // Reference model: raw samples of each open block, averaged with plain integer arithmetic.
    logic [31:0] b_ph [CH][16];
    logic [31:0] b_ac [CH][16];
    int          b_cnt [CH];
    int          model_n;
    logic        exp_vld, exp_err;
    logic [2:0]  exp_chan;
    logic [31:0] exp_ph, exp_ac;
    int          cur_ms;
    logic        cur_ordy;

    task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h at %0t", tag, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        exp_vld = 0; exp_err = 0; exp_chan = 0; exp_ph = 0; exp_ac = 0;
        model_n = 0;
        for (int c = 0; c < CH; c++) b_cnt[c] = 0;
    endtask

    task automatic complete(input int ch);
        longint s_ph = 0;
        longint s_ac = 0;
        longint den;
        longint q;
        logic [31:0] r;
        logic signed [31:0] dd;
        den = longint'(1) << model_n;
        r = b_ph[ch][0];
        for (int k = 0; k < b_cnt[ch]; k++) begin
            dd = b_ph[ch][k] - r;
            s_ph += longint'(dd);
            s_ac += longint'({32'b0, b_ac[ch][k]});
        end
        q = s_ph / den;
        if ((s_ph % den) != 0 && s_ph < 0) q = q - 1;
        exp_vld  = 1;
        exp_chan = 3'(ch);
        exp_ph   = r + q[31:0];
        exp_ac   = 32'(s_ac / den);
    endtask

    task automatic step(input logic vld, input int ch, input logic [31:0] ph,
                        input logic [31:0] ac, input logic clr);
        int   sat;
        logic exp_rdy, take, loaded;
        i_vld = vld; i_chan = 3'(ch); i_ph = ph; i_ac = ac;
        i_mean_steps = 3'(cur_ms); i_clr = clr; o_rdy = cur_ordy;
        #2;
        sat = (cur_ms > MSM) ? MSM : cur_ms;
        exp_rdy = (!exp_vld || cur_ordy) && !clr && (sat == model_n);
        check_eq("i_rdy", {63'b0, i_rdy}, {63'b0, exp_rdy});
        take = vld && exp_rdy;
        @(posedge clk);
        #1;
        if (clr || sat != model_n) begin
            for (int c = 0; c < CH; c++) b_cnt[c] = 0;
            model_n = sat;
        end
        loaded = 0;
        if (take) begin
            if (ch >= CH) exp_err = 1;
            else begin
                b_ph[ch][b_cnt[ch]] = ph;
                b_ac[ch][b_cnt[ch]] = ac;
                b_cnt[ch]++;
                if (b_cnt[ch] == (1 << model_n)) begin
                    complete(ch);
                    loaded = 1;
                    b_cnt[ch] = 0;
                end
            end
        end
        if (!loaded && cur_ordy) exp_vld = 0;
        check_eq("o_vld",  {63'b0, o_vld}, {63'b0, exp_vld});
        check_eq("o_chan", {61'b0, o_chan}, {61'b0, exp_chan});
        check_eq("o_ph",   {32'b0, o_ph}, {32'b0, exp_ph});
        check_eq("o_ac",   {32'b0, o_ac}, {32'b0, exp_ac});
        check_eq("o_err",  {63'b0, o_err}, {63'b0, exp_err});
    endtask

    task automatic send(input int ch, input logic [31:0] ph, input logic [31:0] ac);
        step(1'b1, ch, ph, ac, 1'b0);
    endtask

    task automatic idle();
        step(1'b0, 0, 32'h0, 32'h0, 1'b0);
    endtask

    task automatic check_rst_outputs();
        check_eq("rst_o_vld",  {63'b0, o_vld}, 64'd0);
        check_eq("rst_o_chan", {61'b0, o_chan}, 64'd0);
        check_eq("rst_o_ph",   {32'b0, o_ph}, 64'd0);
        check_eq("rst_o_ac",   {32'b0, o_ac}, 64'd0);
        check_eq("rst_o_err",  {63'b0, o_err}, 64'd0);
    endtask

    task automatic do_reset();
        rstn = 1'b0;
        #1;
        check_rst_outputs();
        model_reset();
        #2;
        rstn = 1'b1;
    endtask

    initial begin
        rstn = 1'b0; i_vld = 0; i_chan = 0; i_ph = 0; i_ac = 0;
        i_mean_steps = 0; i_clr = 0; o_rdy = 1;
        cur_ms = 0; cur_ordy = 1;
        model_reset();
        #3;
        check_rst_outputs();
        #10;
        rstn = 1'b1;
        @(posedge clk);
        #1;

        // T1: n=1 basic average
        cur_ms = 1;
        idle();
        send(0, 32'd100, 32'd10);
        send(0, 32'd300, 32'd21);
        check_eq("t1_ph", {32'b0, o_ph}, 64'd200);
        check_eq("t1_ac", {32'b0, o_ac}, 64'd15);

        // T2: wrap-safe phase and floor rounding
        send(1, 32'h7FFF_FFF0, 32'd0);
        send(1, 32'h8000_0010, 32'd0);
        check_eq("t2_wrap", {32'b0, o_ph}, 64'h8000_0000);
        send(1, -32'sd4, 32'd3);
        send(1, -32'sd3, 32'd4);
        check_eq("t2_floor_ph", {32'b0, o_ph}, 64'hFFFF_FFFC);
        check_eq("t2_floor_ac", {32'b0, o_ac}, 64'd3);

        // T3: n=2 round-robin over four channels at full rate
        cur_ms = 2;
        idle();
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                send(c, 32'(1000 * c + 7 * r), 32'(50 + r + c));

        // T4: output back-pressure
        cur_ms = 1;
        idle();
        send(2, 32'd40, 32'd8);
        send(2, 32'd60, 32'd9);
        cur_ordy = 0;
        for (int k = 0; k < 10; k++) send(3, 32'(k), 32'(k));
        check_eq("t4_held_ph", {32'b0, o_ph}, 64'd50);
        cur_ordy = 1;
        send(3, 32'd5, 32'd5);
        send(3, 32'd7, 32'd7);

        // T5: mode change discards partial block, then saturation
        send(2, 32'd100, 32'd0);
        cur_ms = 2;
        idle();
        send(2, 32'd4, 32'd1);
        send(2, 32'd8, 32'd2);
        send(2, 32'd12, 32'd3);
        send(2, 32'd16, 32'd4);
        check_eq("t5_ph", {32'b0, o_ph}, 64'd10);
        check_eq("t5_ac", {32'b0, o_ac}, 64'd2);
        cur_ms = 7;
        idle();
        cur_ms = 5;
        idle();
        for (int k = 0; k < 16; k++) send(0, 32'(2 * k), 32'(k));
        check_eq("t5_sat_ph", {32'b0, o_ph}, 64'd15);
        check_eq("t5_sat_ac", {32'b0, o_ac}, 64'd7);

        // n=0 passthrough
        cur_ms = 0;
        idle();
        send(1, 32'd12345, 32'd678);
        check_eq("n0_ph", {32'b0, o_ph}, 64'd12345);
        send(4, -32'sd7, 32'd9);
        check_eq("n0_neg_ph", {32'b0, o_ph}, 64'hFFFF_FFF9);

        // i_clr discards a partial block
        cur_ms = 1;
        idle();
        send(0, 32'd1000, 32'd1);
        step(1'b1, 0, 32'd2000, 32'd2, 1'b1);
        send(0, 32'd50, 32'd4);
        send(0, 32'd70, 32'd6);
        check_eq("clr_ph", {32'b0, o_ph}, 64'd60);
        check_eq("clr_ac", {32'b0, o_ac}, 64'd5);

        // T6: invalid channels are dropped and flagged
        send(5, 32'd1, 32'd1);
        send(7, 32'd2, 32'd2);
        check_eq("t6_err", {63'b0, o_err}, 64'd1);
        check_eq("t6_novld", {63'b0, o_vld}, 64'd0);

        // Mid-block reset
        cur_ms = 2;
        idle();
        send(0, 32'd10, 32'd1);
        send(0, 32'd20, 32'd1);
        do_reset();
        idle();
        send(0, 32'd1000, 32'd4);
        send(0, 32'd1004, 32'd4);
        send(0, 32'd1008, 32'd4);
        send(0, 32'd1012, 32'd4);
        check_eq("rst_clean_ph", {32'b0, o_ph}, 64'd1006);

        // Random traffic
        for (int it = 0; it < 1500; it++) begin
            logic [31:0] ph;
            if ($urandom_range(0, 99) < 2) cur_ms = $urandom_range(0, 7);
            cur_ordy = ($urandom_range(0, 3) != 0);
            ph = ($urandom_range(0, 1) == 1) ? $urandom : (32'h7FFF_FFF0 + 32'($urandom_range(0, 31)));
            step($urandom_range(0, 3) != 0, $urandom_range(0, 5), ph, $urandom,
                 $urandom_range(0, 99) == 0);
        end

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
